cpdr_capture: RTL and testbench
===============================

Name: cpdr_capture

Overview:
- Parametrised successor to the single CPDR debug register: captures integer-register values written by CPDR instructions into NUM_CH per-channel shadow registers.
- Also queues every capture as a (channel, data) record in a FIFO for a host/UART drain port with a valid/ready handshake.
- Sits beside Controller/DataPath in the CPU top and taps instr0, current_state and ireg_d0.

Parameters:
- DATA_W, 32: captured data width.
- CH_W, 2: channel-index width.
- NUM_CH, 4: number of shadow registers (≤ 2**CH_W).
- DEPTH, 8: FIFO entries (power of 2).
- AW, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- instr0  in  32  current instruction word.
- current_state  in  4  controller state.
- ireg_d0  in  DATA_W  integer-register read port 0 data.
- clear  in  1  synchronous clear of shadow regs, flags, counters and FIFO.
- dr  out  NUM_CH*DATA_W  shadow registers; channel k at [k*DATA_W +: DATA_W].
- dr_written  out  NUM_CH  sticky per-channel "written since reset/clear".
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_ch  out  CH_W  head record channel.
- out_data  out  DATA_W  head record data.
- fifo_count  out  AW+1  occupancy.
- ovf_count  out  16  dropped-record counter, saturating.
- ch_err  out  1  sticky: CPDR addressed a channel ≥ NUM_CH.

Behaviour:
- Reset (async) and clear (sync): all outputs 0; FIFO empty; edge-detect register 0. clear has priority over a same-cycle capture or pop.
- Match condition: instr0[31:24]==8'hD3 && current_state==`STATE_EXEC (def.v). Channel ch = instr0[8+CH_W-1:8].
- Capture fires only on the first cycle of a match run (match && !match_q), so one CPDR yields exactly one record even if EXEC lasts several cycles.
- On capture with ch < NUM_CH, at the next clk edge:
  - dr[ch] <= ireg_d0; dr_written[ch] <= 1.
  - Push {ch, ireg_d0} to the FIFO.
- On capture with ch ≥ NUM_CH: no dr update, no push, ch_err <= 1.
- FIFO: first-word-fall-through; out_valid = (count != 0); out_ch/out_data show the head combinationally from storage.
  - Pop when out_valid && out_ready.
  - When empty, out_data/out_ch hold the last-read slot content.
  - Pointers wrap modulo DEPTH; count is AW+1 bits, so full = (count == DEPTH).
- Full with no pop: push is dropped, dr still updated, ovf_count += 1, saturating at 16'hFFFF.
- Full with a same-cycle pop: push accepted; count unchanged.
- Empty with a same-cycle push: no pop (out_valid was 0); the record appears with out_valid=1 on the next cycle.
- Latency: capture cycle → dr and out_valid visible 1 cycle later.
- reset asserted mid-drain discards the FIFO contents immediately.

Optional Feature:
- Macro CPDR_TIMESTAMP_EN.
- With it defined:
  - A 32-bit free-running cycle counter (reset 0, wraps, not cleared by clear) is stored with each record.
  - Extra output port out_ts [31:0] presents the head record's timestamp (0 on reset).
  - ovf_count behaviour is unchanged.
- Without it: no counter, no out_ts port; record width is CH_W+DATA_W.

Test Plan:
- Reset, then CPDR ch=1 with ireg_d0=32'hDEADBEEF, EXEC held 3 cycles → dr[1]=DEADBEEF one cycle after the first EXEC cycle; exactly one record; fifo_count=1; out_ch=1.
- 10 CPDRs to ch0 with data 0..9 and out_ready=0 (DEPTH=8) → fifo_count=8; ovf_count=2; dr[0]=9; drain yields 0..7 in order.
- Full FIFO with out_ready=1 and a CPDR in the same cycle → count stays 8; ovf_count unchanged; new record last out.
- CPDR ch=3 with NUM_CH=3 → ch_err=1; dr unchanged; no push; then clear=1 → ch_err=0, dr=0, fifo_count=0.
- Assert reset asynchronously (between edges) while fifo_count=5 → out_valid=0, fifo_count=0, dr=0 immediately.
- With CPDR_TIMESTAMP_EN: CPDRs at cycles 20 and 25 after reset → out_ts=20 then 25.

Source files
------------

// File: rtl/cpdr_capture.sv
// cpdr_capture: latches CPDR-written register values into NUM_CH shadow registers and queues
// (channel, data) records in a first-word-fall-through FIFO for a host drain port.
// Optional: define CPDR_TIMESTAMP_EN to tag each record with a free-running cycle count on out_ts.
module cpdr_capture #(
  parameter int         DATA_W     = 32,
  parameter int         CH_W       = 2,
  parameter int         NUM_CH     = 4,
  parameter int         DEPTH      = 8,
  parameter int         AW         = 3,
  parameter logic [3:0] STATE_EXEC = 4'd3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              instr0,
  input  logic [3:0]               current_state,
  input  logic [DATA_W-1:0]        ireg_d0,
  input  logic                     clear,
  output logic [NUM_CH*DATA_W-1:0] dr,
  output logic [NUM_CH-1:0]        dr_written,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic [AW:0]              fifo_count,
  output logic [15:0]              ovf_count,
  output logic                     ch_err
`ifdef CPDR_TIMESTAMP_EN
  ,
  output logic [31:0]              out_ts
`endif
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);
  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);

  logic              match;
  logic              match_q;
  logic              capture;
  logic              cap_ok;
  logic              full;
  logic              do_pop;
  logic              do_push;
  logic              ovf_hit;
  logic [CH_W-1:0]   cap_ch;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     head_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] dr_q     [NUM_CH];
  logic [CH_W-1:0]   mem_ch   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              unused_instr_bits;

`ifdef CPDR_TIMESTAMP_EN
  logic [31:0]       ts_cnt;
  logic [31:0]       mem_ts   [DEPTH];
`endif

  assign unused_instr_bits = ^{instr0[23:8+CH_W], instr0[7:0]};

  // Only the first cycle of a CPDR match run captures, so a multi-cycle EXEC yields one record.
  assign match   = (instr0[31:24] == 8'hD3) && (current_state == STATE_EXEC);
  assign capture = match && !match_q;
  assign cap_ch  = instr0[8 +: CH_W];
  assign cap_ok  = capture && ({1'b0, cap_ch} < NUM_CH_V);

  assign full      = (count == DEPTH_V);
  assign out_valid = (count != '0);
  assign do_pop    = out_valid && out_ready;
  assign do_push   = cap_ok && (!full || do_pop);
  assign ovf_hit   = cap_ok && full && !do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q    <= 1'b0;
      dr_written <= '0;
      ch_err     <= 1'b0;
      ovf_count  <= '0;
      for (int k = 0; k < NUM_CH; k++) dr_q[k] <= '0;
    end else if (clear) begin
      match_q    <= 1'b0;
      dr_written <= '0;
      ch_err     <= 1'b0;
      ovf_count  <= '0;
      for (int k = 0; k < NUM_CH; k++) dr_q[k] <= '0;
    end else begin
      match_q <= match;
      for (int k = 0; k < NUM_CH; k++) begin
        if (cap_ok && (cap_ch == CH_W'(k))) begin
          dr_q[k]       <= ireg_d0;
          dr_written[k] <= 1'b1;
        end
      end
      if (capture && !cap_ok) ch_err <= 1'b1;
      if (ovf_hit && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dr
    assign dr[g*DATA_W +: DATA_W] = dr_q[g];
  end

  // Pointers rely on DEPTH being a power of two so they wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_ch[k]   <= '0;
        mem_data[k] <= '0;
`ifdef CPDR_TIMESTAMP_EN
        mem_ts[k]   <= '0;
`endif
      end
    end else if (clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_ch[k]   <= '0;
        mem_data[k] <= '0;
`ifdef CPDR_TIMESTAMP_EN
        mem_ts[k]   <= '0;
`endif
      end
    end else if (do_push) begin
      mem_ch[wr_ptr]   <= cap_ch;
      mem_data[wr_ptr] <= ireg_d0;
`ifdef CPDR_TIMESTAMP_EN
      mem_ts[wr_ptr]   <= ts_cnt;
`endif
    end
  end

`ifdef CPDR_TIMESTAMP_EN
  // Free-running stamp; deliberately untouched by clear so host time stays monotonic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  // An empty FIFO keeps showing the slot that was read last.
  assign head_ptr   = out_valid ? rd_ptr : rd_ptr - 1'b1;
  assign out_ch     = mem_ch[head_ptr];
  assign out_data   = mem_data[head_ptr];
  assign fifo_count = count;
`ifdef CPDR_TIMESTAMP_EN
  assign out_ts     = mem_ts[head_ptr];
`endif

endmodule

// File: tb/tb_cpdr_capture.sv
// tb_cpdr_capture: randomized + directed scoreboard bench for cpdr_capture (NUM_CH=3, DEPTH=8).
// Build with CPDR_TIMESTAMP_EN defined to also score the record timestamps.
`timescale 1ns/1ps
module tb_cpdr_capture;
  localparam int         DATA_W = 32;
  localparam int         CH_W   = 2;
  localparam int         NUM_CH = 3;
  localparam int         DEPTH  = 8;
  localparam int         AW     = 3;
  localparam logic [3:0] EXEC   = 4'd5;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     clear;
  logic                     out_ready;
  logic [31:0]              instr0;
  logic [3:0]               current_state;
  logic [DATA_W-1:0]        ireg_d0;
  logic [NUM_CH*DATA_W-1:0] dr;
  logic [NUM_CH-1:0]        dr_written;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic [DATA_W-1:0]        out_data;
  logic [AW:0]              fifo_count;
  logic [15:0]              ovf_count;
  logic                     ch_err;
`ifdef CPDR_TIMESTAMP_EN
  logic [31:0]              out_ts;
`endif

  cpdr_capture #(
    .DATA_W(DATA_W), .CH_W(CH_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .AW(AW), .STATE_EXEC(EXEC)
  ) dut (
    .clk(clk), .reset(reset), .instr0(instr0), .current_state(current_state),
    .ireg_d0(ireg_d0), .clear(clear), .dr(dr), .dr_written(dr_written),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .fifo_count(fifo_count), .ovf_count(ovf_count), .ch_err(ch_err)
`ifdef CPDR_TIMESTAMP_EN
    , .out_ts(out_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [31:0]       ts;
  } rec_t;

  rec_t              sbq[$];
  int                checks = 0;
  int                passed = 0;
  logic [DATA_W-1:0] m_dr [NUM_CH];
  logic [NUM_CH-1:0] m_written;
  int                m_count;
  int                m_ovf;
  logic              m_err;
  logic              m_prev_match;
  logic [31:0]       tb_cycle;

  // Reference cycle count: number of clock edges since reset released.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cycle <= '0;
    else       tb_cycle <= tb_cycle + 32'd1;
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic model_reset();
    sbq.delete();
    for (int k = 0; k < NUM_CH; k++) m_dr[k] = '0;
    m_written    = '0;
    m_count      = 0;
    m_ovf        = 0;
    m_err        = 1'b0;
    m_prev_match = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [NUM_CH*DATA_W-1:0] e_dr;
    for (int k = 0; k < NUM_CH; k++) e_dr[k*DATA_W +: DATA_W] = m_dr[k];
    check_output({tag, ":dr"}, dr, e_dr);
    check_output({tag, ":dr_written"}, dr_written, m_written);
    check_output({tag, ":fifo_count"}, fifo_count, m_count);
    check_output({tag, ":out_valid"}, out_valid, m_count != 0);
    check_output({tag, ":ovf_count"}, ovf_count, m_ovf);
    check_output({tag, ":ch_err"}, ch_err, m_err);
  endtask

  // One clock of stimulus; the model is advanced to the state after the coming edge.
  task automatic apply_stimulus(input logic cpdr, input logic exec, input logic [CH_W-1:0] ch,
                                input logic [31:0] data, input logic rdy, input logic clr);
    logic [7:0] opc;
    logic [3:0] st;
    logic       match;
    logic       pop;
    logic       push;
    rec_t       r;
    @(negedge clk);
    opc = 8'($urandom);
    if (opc == 8'hD3) opc = 8'h00;
    st = 4'($urandom);
    if (st == EXEC) st = 4'(EXEC + 1);
    instr0        = {cpdr ? 8'hD3 : opc, 14'($urandom), ch, 8'($urandom)};
    current_state = exec ? EXEC : st;
    ireg_d0       = data;
    out_ready     = rdy;
    clear         = clr;
    match = cpdr && exec;
    pop   = rdy && !clr && (m_count > 0);
    push  = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (match && !m_prev_match) begin
        if (int'(ch) < NUM_CH) begin
          m_dr[ch]      = data;
          m_written[ch] = 1'b1;
          if (m_count < DEPTH || pop) begin
            r.ch = ch; r.data = data; r.ts = tb_cycle;
            sbq.push_back(r);
            push = 1'b1;
          end else if (m_ovf < 65535) begin
            m_ovf++;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      m_count = m_count + int'(push) - int'(pop);
    end
    m_prev_match = clr ? 1'b0 : match;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, '0, '0, rdy, 1'b0);
  endtask

  // Monitor: whenever the DUT hands over a record, it must be the oldest expected one.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && !clear && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("[TB] FAIL pop_unexpected: got ch=%0d data='h%0h, expected no record", out_ch, out_data);
        end else begin
          r = sbq.pop_front();
          check_output("rec_ch", out_ch, r.ch);
          check_output("rec_data", out_data, r.data);
`ifdef CPDR_TIMESTAMP_EN
          check_output("rec_ts", out_ts, r.ts);
`endif
        end
      end
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; out_ready = 1'b0;
    instr0 = '0; current_state = '0; ireg_d0 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("reset");
    check_output("reset:out_data", out_data, 0);
    check_output("reset:out_ch", out_ch, 0);

    // Single CPDR held in EXEC for three cycles produces one record.
    apply_stimulus(1'b1, 1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0);
    check_state("cpdr_first");
    check_output("cpdr_first:dr1", dr[DATA_W +: DATA_W], 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0);
    check_state("cpdr_held");
    check_output("cpdr_held:count", fifo_count, 1);
    check_output("cpdr_held:head_ch", out_ch, 1);
    idle(1'b1, 3);
    check_state("drain1");

    // Ten captures into a stalled FIFO: eight stored, two dropped.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1, 2'd0, i, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    end
    check_state("overflow");
    check_output("overflow:count", fifo_count, 8);
    check_output("overflow:ovf", ovf_count, 2);
    check_output("overflow:dr0", dr[0 +: DATA_W], 9);

    // Capture coincident with a pop on a full FIFO is accepted.
    apply_stimulus(1'b1, 1'b1, 2'd2, 32'h0000AA55, 1'b1, 1'b0);
    check_state("full_pop");
    check_output("full_pop:count", fifo_count, 8);
    check_output("full_pop:ovf", ovf_count, 2);
    idle(1'b1, 10);
    check_state("drain2");

    // Out-of-range channel flags an error and stores nothing; clear wipes everything.
    apply_stimulus(1'b1, 1'b1, 2'd3, 32'h12345678, 1'b0, 1'b0);
    check_state("ch_err");
    check_output("ch_err:flag", ch_err, 1);
    apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2'd2, 32'h0BADF00D, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 2'd2, '0, 1'b1, 1'b1);
    check_state("clear");
    check_output("clear:count", fifo_count, 0);

    // Asynchronous reset between edges while five records are queued.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b1, 2'(i % NUM_CH), $urandom, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    end
    check_output("pre_async:count", fifo_count, 5);
    @(negedge clk);
    instr0 = '0; current_state = '0; out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_output("async:out_valid", out_valid, 0);
    check_output("async:count", fifo_count, 0);
    check_output("async:dr", dr, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;

    // Randomized traffic with bursts of back-pressure and occasional clears.
    for (int i = 0; i < 800; i++) begin
      logic rdy;
      rdy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      apply_stimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 2'($urandom),
                     $urandom, rdy, $urandom_range(0, 99) == 0);
      check_state("rand");
    end
    idle(1'b1, DEPTH + 2);
    check_state("final");
    check_output("final:sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
